pingpong_input_pacer: RTL and testbench

PINGPONG_INPUT_PACER -- requirements
Module: pingpong_input_pacer

---
 rtl/pingpong_input_pacer.sv | 91 +++++++++
 tb/tb_pingpong_input_pacer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_input_pacer.sv
// Pong input pacer: synchronizes and debounces two player buttons, paces the
// game with a periodic step strobe, and delivers latched press events on it.
module pingpong_input_pacer #(
  parameter int DEB_CNT  = 500000,
  parameter int STEP_CNT = 12500000,
  parameter int CNT_W    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic       run_en,
  output logic       vga_done,
  output logic       left_in,
  output logic       right_in,
  output logic [1:0] btn_level
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CNT - 1);

  // Bit 1 is the left button, bit 0 the right button throughout.
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       level;
  logic [1:0]       press;
  logic [1:0]       pending;
  logic [CNT_W-1:0] step_cnt;
  logic             step_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {btn_left_raw, btn_right_raw};
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        cnt <= '0;
        lvl <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    // The press event fires on the very edge the debounced level rises.
    assign press[i] = sync2[i] & ~lvl & (cnt == DEB_LAST);
    assign level[i] = lvl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (run_en) begin
      step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
    end
  end

  assign step_fire = run_en & (step_cnt == STEP_LAST);

  // Pending flags clear on delivery; a press on the delivery edge is folded in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 2'b00;
      vga_done <= 1'b0;
      left_in  <= 1'b0;
      right_in <= 1'b0;
    end else begin
      pending  <= step_fire ? 2'b00 : (pending | press);
      vga_done <= step_fire;
      left_in  <= step_fire & (pending[1] | press[1]);
      right_in <= step_fire & (pending[0] | press[0]);
    end
  end

  assign btn_level = level;

endmodule

// File: tb/tb_pingpong_input_pacer.sv
// Self-checking bench for pingpong_input_pacer with DEB_CNT=4, STEP_CNT=10:
// expected {left,right} events are queued at stimulus time and popped per strobe.
module tb_pingpong_input_pacer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_left_raw;
  logic       btn_right_raw;
  logic       run_en;
  logic       vga_done;
  logic       left_in;
  logic       right_in;
  logic [1:0] btn_level;

  pingpong_input_pacer #(
    .DEB_CNT (4),
    .STEP_CNT(10),
    .CNT_W   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_left_raw (btn_left_raw),
    .btn_right_raw(btn_right_raw),
    .run_en       (run_en),
    .vga_done     (vga_done),
    .left_in      (left_in),
    .right_in     (right_in),
    .btn_level    (btn_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pl;
    logic       pr;
    int         d;
    logic [1:0] e0;
    logic [1:0] e1;
  } vec_t;

  vec_t       vecs[6];
  logic [1:0] sb[$];
  int         checks = 0;
  int         errors = 0;
  int         run_cnt = 0;
  int         strobes = 0;
  int         rises_l = 0;
  int         rises_r = 0;
  logic [1:0] prev_level = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // A strobe consumes the oldest queued expectation; an empty queue means no event.
  task automatic checkOutput();
    logic [1:0] exp_v;
    strobes++;
    exp_v = (sb.size() > 0) ? sb.pop_front() : 2'b00;
    check("strobe_left", left_in, exp_v[1]);
    check("strobe_right", right_in, exp_v[0]);
    check("strobe_period", run_cnt, 10);
    run_cnt = 0;
  endtask

  task automatic tick();
    if (!rst && run_en) run_cnt++;
    @(negedge clk);
    if (rst) run_cnt = 0;
    if (btn_level[1] && !prev_level[1]) rises_l++;
    if (btn_level[0] && !prev_level[0]) rises_r++;
    prev_level = btn_level;
    if (vga_done) checkOutput();
    else begin
      check("idle_left", left_in, 0);
      check("idle_right", right_in, 0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Each record spans exactly two steps, starting just after a strobe.
  task automatic applyStimulus(input vec_t v);
    sb.push_back(v.e0);
    sb.push_back(v.e1);
    for (int c = 0; c < 20; c++) begin
      btn_left_raw  = v.pl && c >= v.d && c < v.d + 6;
      btn_right_raw = v.pr && c >= v.d && c < v.d + 6;
      tick();
    end
    btn_left_raw  = 1'b0;
    btn_right_raw = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_l;
    int base_r;
    int base_s;

    vecs[0] = '{1'b1, 1'b0, 0, 2'b10, 2'b00};
    vecs[1] = '{1'b0, 1'b1, 2, 2'b01, 2'b00};
    vecs[2] = '{1'b1, 1'b1, 0, 2'b11, 2'b00};
    vecs[3] = '{1'b1, 1'b0, 4, 2'b10, 2'b00};
    vecs[4] = '{1'b0, 1'b1, 5, 2'b00, 2'b01};
    vecs[5] = '{1'b0, 1'b0, 0, 2'b00, 2'b00};

    rst           = 1'b1;
    run_en        = 1'b1;
    btn_left_raw  = 1'b0;
    btn_right_raw = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_vga_done", vga_done, 0);
    check("reset_left_in", left_in, 0);
    check("reset_right_in", right_in, 0);
    check("reset_btn_level", btn_level, 0);

    $display("[TB] idle run: strobes after edges 10, 20, 30");
    rst     = 1'b0;
    run_cnt = 0;
    for (int i = 0; i < 3; i++) sb.push_back(2'b00);
    base_s = strobes;
    ticks(30);
    check("idle_strobe_count", strobes - base_s, 3);
    check("idle_btn_level", btn_level, 0);

    $display("[TB] table-driven press vectors");
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    $display("[TB] left glitches then long hold");
    base_l = rises_l;
    sb.push_back(2'b00);
    sb.push_back(2'b10);
    for (int i = 0; i < 5; i++) sb.push_back(2'b00);
    for (int c = 0; c < 70; c++) begin
      if (c < 12) btn_left_raw = ((c / 3) % 2) == 0;
      else        btn_left_raw = c < 52;
      tick();
    end
    btn_left_raw = 1'b0;
    check("glitch_single_rise", rises_l - base_l, 1);

    $display("[TB] two right presses merged within one paused step");
    base_r = rises_r;
    run_en = 1'b0;
    for (int c = 0; c < 28; c++) begin
      btn_right_raw = (c < 6) || (c >= 14 && c < 20);
      tick();
    end
    btn_right_raw = 1'b0;
    check("merge_two_rises", rises_r - base_r, 2);
    run_en = 1'b1;
    sb.push_back(2'b01);
    sb.push_back(2'b00);
    ticks(20);

    $display("[TB] left press latched across a pause");
    for (int c = 0; c < 8; c++) begin
      btn_left_raw = c < 6;
      tick();
    end
    btn_left_raw = 1'b0;
    run_en = 1'b0;
    base_s = strobes;
    ticks(25);
    check("pause_no_strobe", strobes - base_s, 0);
    run_en = 1'b1;
    sb.push_back(2'b10);
    ticks(2);
    check("resume_strobe", strobes - base_s, 1);

    $display("[TB] reset mid-step with right pending");
    run_en = 1'b0;
    btn_right_raw = 1'b1;
    ticks(8);
    run_en = 1'b1;
    ticks(5);
    check("pre_reset_level", btn_level, 2'b01);
    rst = 1'b1;
    btn_right_raw = 1'b0;
    #1;
    check("async_rst_vga_done", vga_done, 0);
    check("async_rst_left_in", left_in, 0);
    check("async_rst_right_in", right_in, 0);
    check("async_rst_btn_level", btn_level, 0);
    ticks(2);
    rst = 1'b0;
    sb.push_back(2'b00);
    base_s = strobes;
    ticks(9);
    check("post_reset_early", strobes - base_s, 0);
    tick();
    check("post_reset_first_strobe", strobes - base_s, 1);

    $display("[TB] left held through reset release");
    rst = 1'b1;
    btn_left_raw = 1'b1;
    ticks(3);
    rst = 1'b0;
    base_l = rises_l;
    sb.push_back(2'b10);
    sb.push_back(2'b00);
    ticks(20);
    check("held_reset_rise", rises_l - base_l, 1);
    btn_left_raw = 1'b0;
    ticks(10);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
